// File: rtl/vector_lsu.sv
// Vector load/store unit: one request per handshake, bounds-checked base+offset addressing,
// store-side round/saturate of fixed-point lanes to pixels, registered load response.
module vector_lsu #(
    parameter int unsigned ADDRESS_WIDTH = 18,
    parameter int unsigned MEM_SIZE      = 231000,
    parameter int unsigned LANES         = 6,
    parameter int unsigned LANE_WIDTH    = 19,
    parameter int unsigned DATA_WIDTH    = LANES * LANE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_base,
    input  logic [ADDRESS_WIDTH-1:0] req_offset,
    input  logic [DATA_WIDTH-1:0]    req_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     resp_err,
    output logic                     mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0] mem_read_address,
    output logic [ADDRESS_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0]    mem_input_data,
    input  logic [DATA_WIDTH-1:0]    mem_output_data
);

    localparam int unsigned FracBits = 10;
    localparam int unsigned PixBits  = 8;
    localparam logic [ADDRESS_WIDTH:0] MemLimit = (ADDRESS_WIDTH + 1)'(MEM_SIZE);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                   state_q, state_d;
    logic                     op_write_q;
    logic                     err_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;

    logic [ADDRESS_WIDTH:0]   addr_sum;
    logic                     addr_err;
    logic [DATA_WIDTH-1:0]    wdata_conv;
    logic [LANE_WIDTH-1:0]    lane_v;
    logic [PixBits-1:0]       pix;

    // Extra carry bit so base+offset overflow is caught as out of range instead of wrapping.
    assign addr_sum = {1'b0, req_base} + {1'b0, req_offset};
    assign addr_err = (addr_sum >= MemLimit);

    always_comb begin
        wdata_conv = '0;
        lane_v     = '0;
        pix        = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_v = req_data[l*LANE_WIDTH +: LANE_WIDTH];
            if (lane_v[LANE_WIDTH-1]) begin
                pix = '0;
            end else if (&lane_v[FracBits +: PixBits]) begin
                pix = '1;
            end else begin
                pix = lane_v[FracBits +: PixBits] + {{(PixBits-1){1'b0}}, lane_v[FracBits-1]};
            end
            wdata_conv[l*LANE_WIDTH + FracBits +: PixBits] = pix;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready         = (state_q == StIdle);
        resp_valid        = (state_q == StResp);
        resp_err          = (state_q == StResp) && err_q;
        resp_data         = rdata_q;
        mem_write_enable  = (state_q == StAccess) && op_write_q && !err_q;
        mem_read_address  = addr_q;
        mem_write_address = addr_q;
        mem_input_data    = wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                op_write_q <= req_write;
                err_q      <= addr_err;
                addr_q     <= addr_sum[ADDRESS_WIDTH-1:0];
                wdata_q    <= wdata_conv;
            end
            // Stores and faulted accesses return zero data.
            if (state_q == StAccess) begin
                rdata_q <= (!op_write_q && !err_q) ? mem_output_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu: scoreboard of expected responses, write-strobe monitor,
// and a combinational memory model whose read data encodes the read address.
module tb_vector_lsu;

    localparam int unsigned AW = 18;
    localparam int unsigned MEM_SIZE = 231000;
    localparam int unsigned DW = 114;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_base, req_offset;
    logic [DW-1:0] req_data;
    logic          resp_valid, resp_ready, resp_err;
    logic [DW-1:0] resp_data;
    logic          mem_write_enable;
    logic [AW-1:0] mem_read_address, mem_write_address;
    logic [DW-1:0] mem_input_data, mem_output_data;

    int            checks = 0;
    int            errors = 0;
    int            wr_count = 0;
    logic [DW:0]   sb[$];

    vector_lsu dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_base          (req_base),
        .req_offset        (req_offset),
        .req_data          (req_data),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_data         (resp_data),
        .resp_err          (resp_err),
        .mem_write_enable  (mem_write_enable),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_input_data    (mem_input_data),
        .mem_output_data   (mem_output_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return {a, 32'hDEADBEEF ^ {14'b0, a}, 64'h0123_4567_89AB_CDEF};
    endfunction

    assign mem_output_data = pattern(mem_read_address);

    always @(negedge clk) begin
        if (mem_write_enable) wr_count <= wr_count + 1;
    end

    // Half-unit rounding: value in halves, +1, halve, clamp.
    function automatic logic [7:0] pix_model(input logic [18:0] v);
        int h;
        if (v[18]) return 8'd0;
        h = (int'(v[17:9]) + 1) / 2;
        if (h > 255) h = 255;
        return 8'(h);
    endfunction

    function automatic logic [DW-1:0] wdata_model(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < 6; l++) r[l*19+10 +: 8] = pix_model(d[l*19 +: 19]);
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives a request, returns one sample point into the ACCESS cycle.
    task automatic do_req(input logic wr, input logic [AW-1:0] base, input logic [AW-1:0] off,
                          input logic [DW-1:0] data);
        logic [AW:0] sum;
        logic        err;
        int          n;
        req_write  = wr;
        req_base   = base;
        req_offset = off;
        req_data   = data;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            cyc();
            n++;
        end
        chk1("req_accept", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        sum = {1'b0, base} + {1'b0, off};
        err = (sum >= 19'(MEM_SIZE));
        sb.push_back({err, (!wr && !err) ? pattern(sum[AW-1:0]) : {DW{1'b0}}});
    endtask

    task automatic wait_resp(input string tag);
        logic [DW:0] e;
        int          n;
        n = 0;
        while (!resp_valid && n < 10) begin
            cyc();
            n++;
        end
        chk1({tag, "_valid"}, resp_valid, 1'b1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk1({tag, "_err"}, resp_err, e[DW]);
        chkd({tag, "_data"}, resp_data, e[DW-1:0]);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk1({tag, "_drop"}, resp_valid, 1'b0);
    endtask

    initial begin
        logic [18:0]   lv[6];
        logic [7:0]    pb[6];
        logic [DW-1:0] sd, exp_d, r2;
        logic [DW:0]   e;
        logic [AW-1:0] rb;
        int            wc0;

        lv = '{19'h7FFFF, 19'h3FE00, 19'h03200, 19'h03100, 19'h00000, 19'h19000};
        pb = '{8'd0, 8'd255, 8'd13, 8'd12, 8'd0, 8'd100};
        sd = '0;
        exp_d = '0;
        for (int l = 0; l < 6; l++) begin
            sd[l*19 +: 19]       = lv[l];
            exp_d[l*19+10 +: 8] = pb[l];
        end

        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_base = '0;
        req_offset = '0;
        req_data = '0;
        resp_ready = 1'b0;
        repeat (2) cyc();
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk1("rst_we", mem_write_enable, 1'b0);
        chkd("rst_resp_data", resp_data, '0);
        chka("rst_raddr", mem_read_address, '0);
        chka("rst_waddr", mem_write_address, '0);
        chkd("rst_wdata", mem_input_data, '0);
        rst = 1'b0;
        cyc();

        // Rounding / saturation store
        wc0 = wr_count;
        do_req(1'b1, 18'd500, 18'd7, sd);
        chk1("st_we", mem_write_enable, 1'b1);
        chka("st_waddr", mem_write_address, 18'd507);
        chkd("st_wdata", mem_input_data, exp_d);
        chk1("st_req_ready", req_ready, 1'b0);
        chk1("st_early_valid", resp_valid, 1'b0);
        cyc();
        chk1("st_we_one_cycle", mem_write_enable, 1'b0);
        chk1("st_latency", resp_valid, 1'b1);
        wait_resp("st");
        chki("st_wr_count", wr_count, wc0 + 1);

        // Load with back-pressure and a queued second request
        do_req(1'b0, 18'd1000, 18'd24, '0);
        chka("ld_raddr", mem_read_address, 18'd1024);
        chk1("ld_we", mem_write_enable, 1'b0);
        cyc();
        chk1("ld_valid", resp_valid, 1'b1);
        r2 = DW'({$urandom, $urandom, $urandom, $urandom});
        req_write = 1'b1;
        req_base = 18'd20;
        req_offset = 18'd3;
        req_data = r2;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk1("bp_req_ready", req_ready, 1'b0);
            chk1("bp_valid_held", resp_valid, 1'b1);
            chkd("bp_data_stable", resp_data, pattern(18'd1024));
        end
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk1("ld_err", resp_err, e[DW]);
        chkd("ld_data", resp_data, e[DW-1:0]);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk1("bp_drop", resp_valid, 1'b0);
        chk1("bp_idle_ready", req_ready, 1'b1);
        sb.push_back('0);
        cyc();
        req_valid = 1'b0;
        chk1("bp2_accepted", req_ready, 1'b0);
        chk1("bp2_we", mem_write_enable, 1'b1);
        chka("bp2_waddr", mem_write_address, 18'd23);
        chkd("bp2_wdata", mem_input_data, wdata_model(r2));
        wait_resp("bp2");

        // Out of range, last valid address, and wrap-around
        wc0 = wr_count;
        do_req(1'b1, 18'd230990, 18'd10, sd);
        chk1("oor_we", mem_write_enable, 1'b0);
        wait_resp("oor");
        do_req(1'b0, 18'd230990, 18'd9, '0);
        chka("edge_raddr", mem_read_address, 18'd230999);
        wait_resp("edge");
        do_req(1'b1, 18'h3FFFF, 18'd1, sd);
        chk1("wrap_we", mem_write_enable, 1'b0);
        wait_resp("wrap_st");
        do_req(1'b0, 18'h3FFFF, 18'd1, '0);
        wait_resp("wrap_ld");
        chki("err_no_writes", wr_count, wc0);

        // Random stores against the pixel model
        for (int i = 0; i < 4; i++) begin
            rb = 18'($urandom_range(0, 100000));
            r2 = DW'({$urandom, $urandom, $urandom, $urandom});
            do_req(1'b1, rb, 18'd77, r2);
            chka("rnd_waddr", mem_write_address, rb + 18'd77);
            chkd("rnd_wdata", mem_input_data, wdata_model(r2));
            wait_resp("rnd");
        end

        // Reset while a store is in ACCESS
        wc0 = wr_count;
        do_req(1'b1, 18'd40, 18'd2, sd);
        void'(sb.pop_back());
        chk1("mr_pending", mem_write_enable, 1'b1);
        rst = 1'b1;
        #1;
        chk1("mr_we", mem_write_enable, 1'b0);
        chk1("mr_req_ready", req_ready, 1'b1);
        chk1("mr_resp_valid", resp_valid, 1'b0);
        chkd("mr_wdata", mem_input_data, '0);
        cyc();
        rst = 1'b0;
        repeat (3) cyc();
        chki("mr_no_write", wr_count, wc0);
        chk1("mr_still_idle", resp_valid, 1'b0);

        do_req(1'b0, 18'd5, 18'd5, '0);
        wait_resp("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
